code_fifo_reader: RTL and testbench

Consumer end of the code-side FIFO. It drains decrypted instruction words, which the fetch/decrypt FSM writes into the FIFO, and hands them to the decode stage over a valid/ready handshake. It tags each word with its PC. On a taken branch it discards all buffered and in-flight words, pulses a branch request back to the fetch side, and waits out the FIFO reset before it resumes delivery.

---
 rtl/code_fifo_reader_pkg.sv | 14 +
 rtl/code_fifo_reader_skid_buf.sv | 87 ++++++++
 rtl/code_fifo_reader.sv | 123 ++++++++++++
 tb/tb_code_fifo_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_fifo_reader_pkg.sv
// rtl/code_fifo_reader_pkg.sv - shared types and width defaults for the code-side FIFO reader
package code_fifo_reader_pkg;

    // Reader state: delivering words, or discarding them after a redirect
    typedef enum logic {
        RUN        = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_e;

    // Widths shared with the fetch/decrypt FSM
    localparam int CODE_DATA_W = 64;
    localparam int CODE_ADDR_W = 13;

endpackage

// File: rtl/code_fifo_reader_skid_buf.sv
// rtl/code_fifo_reader_skid_buf.sv - two-entry {data, pc} output buffer with push/pop/clear
module instr_skid_buf
    import code_fifo_reader_pkg::*;
#(
    parameter int                DATA_W   = CODE_DATA_W,
    parameter int                ADDR_W   = CODE_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_pc,
    output logic              head_valid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop;
    logic              do_push;

    // Entry 0 is always the head; a pop shifts entry 1 down, a push fills the first free slot
    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && (do_pop || (count_q != 2'd2));
        if (clear) begin
            count_d = 2'd0;
        end else if (do_pop && do_push) begin
            if (count_q == 2'd1) begin
                data0_d = push_data;
                pc0_d   = push_pc;
            end else begin
                data0_d = data1_q;
                pc0_d   = pc1_q;
                data1_d = push_data;
                pc1_d   = push_pc;
            end
        end else if (do_pop) begin
            data0_d = data1_q;
            pc0_d   = pc1_q;
            count_d = count_q - 2'd1;
        end else if (do_push) begin
            if (count_q == 2'd0) begin
                data0_d = push_data;
                pc0_d   = push_pc;
            end else begin
                data1_d = push_data;
                pc1_d   = push_pc;
            end
            count_d = count_q + 2'd1;
        end
    end

    // Buffer storage; the head PC resets to RESET_PC so instr_pc does too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_q <= '0;
            data1_q <= '0;
            pc0_q   <= RESET_PC;
            pc1_q   <= '0;
            count_q <= 2'd0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            count_q <= count_d;
        end
    end

    assign head_data  = data0_q;
    assign head_pc    = pc0_q;
    assign head_valid = (count_q != 2'd0);
    assign count      = count_q;

endmodule

// File: rtl/code_fifo_reader.sv
// rtl/code_fifo_reader.sv - drains decrypted code words from the FIFO into decode, PC-tagged, with branch flush
module code_fifo_reader
    import code_fifo_reader_pkg::*;
#(
    parameter int                DATA_W    = CODE_DATA_W,
    parameter int                ADDR_W    = CODE_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                FLUSH_MIN = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic              fifo_rd_rst_busy,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              pc_inp_sel_en,
    output logic [ADDR_W-1:0] pc_target
);

    localparam int CNT_W = (FLUSH_MIN < 1) ? 1 : $clog2(FLUSH_MIN + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_target_q, pc_target_d;
    logic              inflight_q, inflight_d;
    logic              pc_sel_q, pc_sel_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [1:0]        buf_count;
    logic              buf_valid;
    logic              pop;
    logic              push;
    logic              rd_en;

    // Read issue: a word leaving this cycle frees its slot, which keeps one word per cycle flowing
    always_comb begin
        pop   = buf_valid && instr_ready;
        rd_en = 1'b0;
        if ((state_q == RUN) && !fifo_empty && !branch_taken) begin
            rd_en = (({1'b0, buf_count} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
        end
    end

    assign push       = inflight_q && !branch_taken;
    assign fifo_rd_en = rd_en;

    // Next state: a branch overrides everything and restarts the flush; otherwise count down the flush
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pc_target_d = pc_target_q;
        inflight_d  = rd_en;
        pc_sel_d    = 1'b0;
        flush_cnt_d = flush_cnt_q;
        if (branch_taken) begin
            state_d     = FLUSH_WAIT;
            fetch_pc_d  = branch_target;
            pc_target_d = branch_target;
            pc_sel_d    = 1'b1;
            flush_cnt_d = CNT_W'(FLUSH_MIN);
            inflight_d  = 1'b0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
            if (state_q == FLUSH_WAIT) begin
                if (flush_cnt_q != '0) begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
                if ((flush_cnt_d == '0) && !fifo_rd_rst_busy) begin
                    state_d = RUN;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            pc_target_q <= '0;
            inflight_q  <= 1'b0;
            pc_sel_q    <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pc_target_q <= pc_target_d;
            inflight_q  <= inflight_d;
            pc_sel_q    <= pc_sel_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    instr_skid_buf #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_skid_buf (
        .clk        (clk),
        .rst_n      (reset_n),
        .clear      (branch_taken),
        .push       (push),
        .push_data  (fifo_dout),
        .push_pc    (fetch_pc_q),
        .pop        (pop),
        .head_data  (instr_data),
        .head_pc    (instr_pc),
        .head_valid (buf_valid),
        .count      (buf_count)
    );

    assign instr_valid   = buf_valid;
    assign pc_inp_sel_en = pc_sel_q;
    assign pc_target     = pc_target_q;

endmodule

// File: tb/tb_code_fifo_reader.sv
// tb/tb_code_fifo_reader.sv - self-checking bench for code_fifo_reader
module tb_code_fifo_reader;

    localparam int          DATA_W    = 64;
    localparam int          ADDR_W    = 13;
    localparam int          FLUSH_MIN = 3;
    localparam logic [12:0] RESET_PC  = 13'h0000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd_rst_busy;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              pc_inp_sel_en;
    logic [ADDR_W-1:0] pc_target;

    code_fifo_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fifo_dout        (fifo_dout),
        .fifo_empty       (fifo_empty),
        .fifo_rd_rst_busy (fifo_rd_rst_busy),
        .fifo_rd_en       (fifo_rd_en),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .pc_inp_sel_en    (pc_inp_sel_en),
        .pc_target        (pc_target)
    );

    always #5 clk = ~clk;

    // FIFO contents and expected decode stream
    logic [DATA_W-1:0]        fifoq[$];
    logic [DATA_W+ADDR_W-1:0] expq[$];
    logic [ADDR_W-1:0]        model_pc;
    logic [ADDR_W-1:0]        exp_target;
    logic [DATA_W+ADDR_W-1:0] prev_word;
    logic                     prev_stall;
    logic                     prev_branch;
    int                       hold;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_rd, first_valid, first_del, last_del, del_cnt, rd_cnt, sel_cnt, br_cyc;
    logic [ADDR_W-1:0] first_del_pc, last_pc;
    logic [DATA_W-1:0] word_a;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        first_rd = -1; first_valid = -1; first_del = -1; last_del = -1;
        del_cnt = 0; rd_cnt = 0; sel_cnt = 0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        fifoq.push_back(d);
        expq.push_back({d, model_pc});
        model_pc   = model_pc + 1'b1;
        fifo_empty = 1'b0;
    endtask

    task automatic observe();
        logic                     rd;
        logic [DATA_W+ADDR_W-1:0] w;
        rd = fifo_rd_en;
        if (rd) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (pc_inp_sel_en) sel_cnt++;
        if (instr_valid && first_valid < 0) first_valid = cyc;
        chk("sel_pulse", pc_inp_sel_en, prev_branch);
        chk("pc_target", pc_target, exp_target);
        if (prev_branch) chk("valid_after_branch", instr_valid, 1'b0);
        if (prev_stall && !prev_branch) begin
            chk("hold_valid", instr_valid, 1'b1);
            chk("hold_word", {instr_data, instr_pc}, prev_word);
        end
        if (hold > 0 || fifo_rd_rst_busy || branch_taken) chk("rd_in_flush", rd, 1'b0);
        if (hold > 0) hold--;
        if (instr_valid && instr_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_word", instr_valid, 1'b0);
            end else begin
                w = expq.pop_front();
                chk("word", {instr_data, instr_pc}, w);
                if (first_del < 0) begin
                    first_del    = cyc;
                    first_del_pc = instr_pc;
                end
                last_del = cyc;
                last_pc  = instr_pc;
                del_cnt++;
            end
        end
        prev_stall  = instr_valid && !instr_ready;
        prev_word   = {instr_data, instr_pc};
        prev_branch = branch_taken;
        if (branch_taken) begin
            expq.delete();
            fifoq.delete();
            model_pc   = branch_target;
            exp_target = branch_target;
            hold       = FLUSH_MIN;
            br_cyc     = cyc;
        end
    endtask

    task automatic tick();
        logic rd;
        @(negedge clk);
        rd = fifo_rd_en;
        observe();
        @(posedge clk);
        #1;
        cyc++;
        if (rd && fifoq.size() > 0) fifo_dout = fifoq.pop_front();
        fifo_empty = (fifoq.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_branch(input logic [ADDR_W-1:0] t);
        branch_taken  = 1'b1;
        branch_target = t;
        tick();
        branch_taken  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; fifo_empty = 1'b1; fifo_rd_rst_busy = 1'b0; fifo_dout = '0;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
        model_pc = RESET_PC; exp_target = '0; prev_word = '0;
        prev_stall = 1'b0; prev_branch = 1'b0; hold = 0; br_cyc = 0;
        first_del_pc = '0; last_pc = '0;
        mark();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_pc", instr_pc, RESET_PC);
        chk("rst_data", instr_data, 64'h0);
        chk("rst_sel", pc_inp_sel_en, 1'b0);
        chk("rst_target", pc_target, 13'h0);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        reset_n = 1'b1;

        // Latency and back-to-back delivery
        mark();
        instr_ready = 1'b1;
        push_word(64'hAAAA_0000_0000_000A);
        push_word(64'hBBBB_0000_0000_000B);
        push_word(64'hCCCC_0000_0000_000C);
        run(10);
        chk("latency", first_valid - first_rd, 2);
        chk("t1_count", del_cnt, 3);
        chk("t1_no_gap", last_del - first_del, 2);
        chk("t1_last_pc", last_pc, 13'h0002);

        // Backpressure
        mark();
        instr_ready = 1'b0;
        word_a = $urandom();
        word_a = {word_a[31:0], 32'($urandom())};
        push_word(word_a);
        for (int i = 0; i < 3; i++) push_word({32'($urandom()), 32'($urandom())});
        run(5);
        chk("bp_reads", rd_cnt, 2);
        chk("bp_head", instr_data, word_a);
        mark();
        instr_ready = 1'b1;
        run(8);
        chk("bp_count", del_cnt, 4);
        chk("bp_no_gap", last_del - first_del, 3);

        // Branch with words buffered
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word({32'($urandom()), 32'($urandom())});
        run(4);
        chk("pre_branch_valid", instr_valid, 1'b1);
        mark();
        do_branch(13'h0100);
        push_word(64'h1111_2222_3333_4444);
        push_word(64'h5555_6666_7777_8888);
        instr_ready = 1'b1;
        run(10);
        chk("br_first_rd", first_rd - br_cyc, 1 + FLUSH_MIN);
        chk("br_sel_cnt", sel_cnt, 1);
        chk("br_first_pc", first_del_pc, 13'h0100);
        chk("br_count", del_cnt, 2);

        // Read-side reset busy extends the flush
        mark();
        do_branch(13'h0040);
        fifo_rd_rst_busy = 1'b1;
        push_word({32'($urandom()), 32'($urandom())});
        push_word({32'($urandom()), 32'($urandom())});
        run(6);
        fifo_rd_rst_busy = 1'b0;
        run(10);
        chk("busy_first_rd", first_rd - br_cyc, 8);
        chk("busy_count", del_cnt, 2);

        // Second branch during the flush
        mark();
        do_branch(13'h0180);
        tick();
        do_branch(13'h0200);
        for (int i = 0; i < 3; i++) push_word({32'($urandom()), 32'($urandom())});
        run(12);
        chk("br2_sel_cnt", sel_cnt, 2);
        chk("br2_first_rd", first_rd - br_cyc, 1 + FLUSH_MIN);
        chk("br2_first_pc", first_del_pc, 13'h0200);
        chk("br2_count", del_cnt, 3);

        // PC wrap
        mark();
        do_branch(13'h1FFE);
        for (int i = 0; i < 3; i++) push_word({32'($urandom()), 32'($urandom())});
        run(10);
        chk("wrap_first_pc", first_del_pc, 13'h1FFE);
        chk("wrap_last_pc", last_pc, 13'h0000);
        chk("wrap_count", del_cnt, 3);

        // Random traffic and backpressure
        mark();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) != 0 && fifoq.size() < 6)
                push_word({32'($urandom()), 32'($urandom())});
            instr_ready = 1'($urandom_range(0, 1));
            tick();
        end
        instr_ready = 1'b1;
        run(12);
        chk("rand_drained", expq.size(), 0);

        // Asynchronous reset mid-stream
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word({32'($urandom()), 32'($urandom())});
        run(4);
        chk("pre_reset_valid", instr_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", instr_valid, 1'b0);
        chk("async_pc", instr_pc, RESET_PC);
        chk("async_sel", pc_inp_sel_en, 1'b0);
        chk("async_target", pc_target, 13'h0);
        expq.delete();
        fifoq.delete();
        fifo_empty = 1'b1;
        model_pc = RESET_PC; exp_target = '0;
        prev_stall = 1'b0; prev_branch = 1'b0; hold = 0;
        run(2);
        reset_n = 1'b1;
        mark();
        instr_ready = 1'b1;
        push_word({32'($urandom()), 32'($urandom())});
        push_word({32'($urandom()), 32'($urandom())});
        run(8);
        chk("restart_pc", first_del_pc, RESET_PC);
        chk("restart_count", del_cnt, 2);
        chk("restart_sel_cnt", sel_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
